// File: rtl/context_engine_pkg.sv
// context_engine_pkg: shared widths and FSM state encoding for the context engine
package context_engine_pkg;
  localparam int REG_IDX_W = 4;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_WR,
    REST_RD,
    REST_WR,
    DONE
  } state_t;
endpackage

// File: rtl/context_engine.sv
// context_engine: saves/restores NUM_REGS registers to/from memory at base_addr + idx*ADDR_STRIDE
//   start_save/start_restore  one-cycle requests, accepted only in IDLE (save wins a tie)
//   busy/done                 operation in flight / one-cycle completion pulse
//   rf_*                      register-file read port (combinational data) and full-word write port
//   mem_*                     req/ack memory port; request held stable until mem_ack
module context_engine
  import context_engine_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_save,
  input  logic                 start_restore,
  input  logic [WORD_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic [REG_IDX_W-1:0] rf_rd_addr,
  input  logic [WORD_W-1:0]    rf_rd_data,
  output logic                 rf_wr,
  output logic [REG_IDX_W-1:0] rf_wr_dst,
  output logic [WORD_W-1:0]    rf_wr_data,
  output logic                 rf_high,
  output logic                 rf_low,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_W-1:0]    mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_W-1:0]    mem_rdata
);
  state_t st, st_n;
  logic [REG_IDX_W-1:0] idx, idx_n;
  logic [WORD_W-1:0] base, base_n, word, word_n, addr;
  logic last;
  assign last = idx == REG_IDX_W'(NUM_REGS - 1);
  // 32-bit add wraps naturally past the top of the address space
  assign addr = base + WORD_W'(idx) * WORD_W'(ADDR_STRIDE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      idx  <= '0;
      base <= '0;
      word <= '0;
    end else begin
      st   <= st_n;
      idx  <= idx_n;
      base <= base_n;
      word <= word_n;
    end
  end
  always_comb begin
    st_n   = st;
    idx_n  = idx;
    base_n = base;
    word_n = word;
    case (st)
      IDLE: begin
        if (start_save || start_restore) begin
          st_n   = start_save ? SAVE_RD : REST_RD;
          idx_n  = '0;
          base_n = base_addr;
        end
      end
      SAVE_RD: begin
        word_n = rf_rd_data;
        st_n   = SAVE_WR;
      end
      SAVE_WR: begin
        if (mem_ack) begin
          st_n  = last ? DONE : SAVE_RD;
          idx_n = last ? idx : idx + 1'b1;
        end
      end
      REST_RD: begin
        if (mem_ack) begin
          word_n = mem_rdata;
          st_n   = REST_WR;
        end
      end
      REST_WR: begin
        st_n  = last ? DONE : REST_RD;
        idx_n = last ? idx : idx + 1'b1;
      end
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  // Outputs decode straight from the reset state so an async reset clears them at once
  assign busy       = st != IDLE && st != DONE;
  assign done       = st == DONE;
  assign mem_req    = st == SAVE_WR || st == REST_RD;
  assign mem_we     = st == SAVE_WR;
  assign mem_addr   = mem_req ? addr : '0;
  assign mem_wdata  = mem_we ? word : '0;
  assign rf_rd_addr = idx;
  assign rf_wr      = st == REST_WR;
  assign rf_wr_dst  = rf_wr ? idx : '0;
  assign rf_wr_data = rf_wr ? word : '0;
  assign rf_high    = 1'b0;
  assign rf_low     = 1'b0;
endmodule

// File: tb/tb_context_engine.sv
// tb_context_engine: directed checks of save/restore, latency, stalls, wrap and reset abort
module tb_context_engine;
  logic clk = 0, rst_n = 0, start_save = 0, start_restore = 0;
  logic [31:0] base_addr = 0;
  logic busy, done, rf_wr, rf_high, rf_low, mem_req, mem_we, mem_ack;
  logic [3:0] rf_rd_addr, rf_wr_dst;
  logic [31:0] rf_rd_data, rf_wr_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] rf [16];
  int ack_wait = 0, wcnt = 0;
  logic ack_force = 0, hold = 0;
  logic [31:0] hold_addr = 0;
  logic [31:0] wr_addr [$], wr_data [$], rw_data [$];
  logic [3:0] rw_dst [$];
  int part_cnt = 0, unstable = 0, checks = 0, passed = 0, k;
  logic pend = 0, p_we;
  logic [31:0] p_addr, p_wdata;

  context_engine dut (
    .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .rf_wr(rf_wr), .rf_wr_dst(rf_wr_dst), .rf_wr_data(rf_wr_data),
    .rf_high(rf_high), .rf_low(rf_low), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign rf_rd_data = rf[rf_rd_addr];
  assign mem_ack = (mem_req && wcnt >= ack_wait && !(hold && mem_addr == hold_addr)) || ack_force;
  assign mem_rdata = 32'h5A5A_0000 + ((mem_addr - 32'h200) >> 2);
  always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

  always @(negedge clk) begin
    if (mem_req && mem_ack && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (rf_wr) begin
      rw_dst.push_back(rf_wr_dst);
      rw_data.push_back(rf_wr_data);
    end
    if (rf_high || rf_low) part_cnt++;
    if (pend && (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata)) unstable++;
    pend = mem_req && !mem_ack;
    p_addr = mem_addr;
    p_we = mem_we;
    p_wdata = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rw_dst.delete();
    rw_data.delete();
    unstable = 0;
  endtask

  // Issue a start and count negedges until done; inj pulses start_restore at that cycle
  task automatic run(input logic sv, input logic rs, input logic [31:0] base, input int inj, output int lat);
    clear_logs();
    start_save = sv;
    start_restore = rs;
    base_addr = base;
    lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start_save = 0;
      start_restore = (c == inj);
      if (c == 1) check("busy_after_start", busy, 1);
      if (done) begin
        lat = c;
        break;
      end
    end
    start_restore = 0;
    check("done_seen", done, 1);
  endtask

  task automatic check_writes(input logic [31:0] base, input logic [31:0] dbase);
    check("wr_count", wr_addr.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wr_addr[i], base + 32'(4 * i));
      check($sformatf("wr_data[%0d]", i), wr_data[i], dbase + 32'(i));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rf_wr", rf_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rf_wr_data", rf_wr_data, 0);
    check("rst_rf_wr_dst", rf_wr_dst, 0);
    check("rst_rf_rd_addr", rf_rd_addr, 0);
    rst_n = 1;
    @(negedge clk);

    run(1, 0, 32'h100, 0, k);
    check("save_latency", k, 33);
    check_writes(32'h100, 32'hA000_0000);
    check("save_no_rf_wr", rw_dst.size(), 0);
    start_save = 1;
    @(negedge clk);
    start_save = 0;
    check("done_pulse_one_cycle", done, 0);
    check("done_start_ignored", busy, 0);
    @(negedge clk);
    check("done_start_ignored2", busy, 0);

    run(0, 1, 32'h200, 0, k);
    check("restore_latency", k, 33);
    check("rw_count", rw_dst.size(), 16);
    for (int i = 0; i < 16 && i < rw_dst.size(); i++) begin
      check($sformatf("rw_dst[%0d]", i), rw_dst[i], 32'(i));
      check($sformatf("rw_data[%0d]", i), rw_data[i], 32'h5A5A_0000 + 32'(i));
    end
    check("restore_no_mem_wr", wr_addr.size(), 0);
    check("partial_writes", part_cnt, 0);
    @(negedge clk);

    ack_wait = 3;
    run(1, 0, 32'h100, 0, k);
    check("stall_latency", k, 81);
    check("stall_stable", unstable, 0);
    check_writes(32'h100, 32'hA000_0000);
    ack_wait = 0;
    @(negedge clk);

    run(1, 1, 32'h100, 11, k);
    check("both_latency", k, 33);
    check_writes(32'h100, 32'hA000_0000);
    check("both_no_restore", rw_dst.size(), 0);
    repeat (3) @(negedge clk);
    check("restore_not_queued", busy, 0);

    run(1, 0, 32'hFFFF_FFF8, 0, k);
    check("wrap_latency", k, 33);
    check_writes(32'hFFFF_FFF8, 32'hA000_0000);
    @(negedge clk);

    clear_logs();
    hold = 1;
    hold_addr = 32'h11C;
    start_save = 1;
    base_addr = 32'h100;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start_save = 0;
      if (mem_req && mem_addr == 32'h11C) break;
    end
    check("rst_reached_idx7", mem_addr, 32'h11C);
    check("rst_idx7_is_write", mem_we, 1);
    #2 rst_n = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_req", mem_req, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    check("abort_rf_rd_addr", rf_rd_addr, 0);
    check("abort_done", done, 0);
    check("abort_wr_count", wr_addr.size(), 7);
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    ack_force = 1;
    repeat (3) @(negedge clk);
    ack_force = 0;
    check("late_ack_busy", busy, 0);
    check("late_ack_mem_req", mem_req, 0);
    check("late_ack_rf_wr", rw_dst.size(), 0);
    check("late_ack_wr_count", wr_addr.size(), 7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
